// File: rtl/rf_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_port_arbiter
// Description : Round-robin register-file port arbiter for two requesters,
//               with bounded locking. Optional macro RF_ARB_BYPASS_EN
//               forwards same-request write data to the read response.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_port_arbiter #(
    parameter int REG_WIDTH = 32,
    parameter int REG_DEPTH = 32,
    parameter int MAX_LOCK  = 4,
    localparam int AW = $clog2(REG_DEPTH)
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [1:0]           req_lock,
    input  logic [1:0]           req_we,
    input  logic [AW-1:0]        req_rs1_0,
    input  logic [AW-1:0]        req_rs1_1,
    input  logic [AW-1:0]        req_rs2_0,
    input  logic [AW-1:0]        req_rs2_1,
    input  logic [AW-1:0]        req_rd_0,
    input  logic [AW-1:0]        req_rd_1,
    input  logic [REG_WIDTH-1:0] req_wdata_0,
    input  logic [REG_WIDTH-1:0] req_wdata_1,
    output logic [1:0]           rsp_valid,
    output logic [REG_WIDTH-1:0] rsp_rd1,
    output logic [REG_WIDTH-1:0] rsp_rd2,
    output logic [AW-1:0]        rf_addr1,
    output logic [AW-1:0]        rf_addr2,
    output logic [AW-1:0]        rf_addr3,
    output logic                 rf_regwrite,
    output logic [REG_WIDTH-1:0] rf_wdata,
    input  logic [REG_WIDTH-1:0] rf_rd1,
    input  logic [REG_WIDTH-1:0] rf_rd2
);

    localparam logic [3:0] c_MAX_LOCK = 4'(MAX_LOCK);

    logic       r_prio;
    logic       r_last_id;
    logic       r_lock_hold;
    logic [3:0] r_lock_cnt;
    logic       r_rsp_pend;
    logic       r_rsp_id;

    logic       w_grant;
    logic       w_win;
    logic       w_other;
    logic       w_cap;
    logic       w_same;
    logic       w_rsp_live;

    assign w_other = ~r_last_id;
    assign w_cap   = r_lock_hold && (r_lock_cnt >= c_MAX_LOCK);
    // A streak continues only if the previous cycle granted the same requester.
    assign w_same  = r_rsp_pend && (w_win == r_last_id);

    always_comb begin
        w_grant = 1'b0;
        w_win   = 1'b0;
        if (!Rst && (|req_valid)) begin
            w_grant = 1'b1;
            if (r_lock_hold && req_valid[r_last_id] && !w_cap) begin
                w_win = r_last_id;
            end else if (w_cap) begin
                w_win = req_valid[w_other] ? w_other : r_last_id;
            end else if (req_valid[r_prio]) begin
                w_win = r_prio;
            end else begin
                w_win = ~r_prio;
            end
        end
    end

    always_comb begin
        req_ready   = 2'b00;
        rf_addr1    = '0;
        rf_addr2    = '0;
        rf_addr3    = '0;
        rf_regwrite = 1'b0;
        rf_wdata    = '0;
        if (w_grant) begin
            req_ready[w_win] = 1'b1;
            rf_addr1    = w_win ? req_rs1_1   : req_rs1_0;
            rf_addr2    = w_win ? req_rs2_1   : req_rs2_0;
            rf_addr3    = w_win ? req_rd_1    : req_rd_0;
            rf_wdata    = w_win ? req_wdata_1 : req_wdata_0;
            rf_regwrite = req_we[w_win];
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_prio      <= 1'b0;
            r_last_id   <= 1'b0;
            r_lock_hold <= 1'b0;
            r_lock_cnt  <= 4'd0;
            r_rsp_pend  <= 1'b0;
            r_rsp_id    <= 1'b0;
        end else begin
            r_rsp_pend <= w_grant;
            r_rsp_id   <= w_win;
            if (w_grant) begin
                r_last_id   <= w_win;
                r_lock_hold <= req_lock[w_win];
                if (!req_lock[w_win]) begin
                    r_prio <= ~w_win;
                end
                if (w_same && !w_cap) begin
                    r_lock_cnt <= (r_lock_cnt == 4'hF) ? 4'hF : r_lock_cnt + 4'd1;
                end else begin
                    r_lock_cnt <= 4'd1;
                end
            end else begin
                r_lock_hold <= 1'b0;
                r_lock_cnt  <= 4'd0;
            end
        end
    end

    assign w_rsp_live = r_rsp_pend && !Rst;

    always_comb begin
        rsp_valid = 2'b00;
        if (w_rsp_live) begin
            rsp_valid[r_rsp_id] = 1'b1;
        end
    end

`ifdef RF_ARB_BYPASS_EN
    logic                 r_byp1;
    logic                 r_byp2;
    logic [REG_WIDTH-1:0] r_byp_wdata;
    logic                 w_wr_live;

    assign w_wr_live = rf_regwrite && (rf_addr3 != '0);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_byp1      <= 1'b0;
            r_byp2      <= 1'b0;
            r_byp_wdata <= '0;
        end else begin
            r_byp1      <= w_wr_live && (rf_addr1 == rf_addr3);
            r_byp2      <= w_wr_live && (rf_addr2 == rf_addr3);
            r_byp_wdata <= rf_wdata;
        end
    end

    assign rsp_rd1 = !w_rsp_live ? '0 : (r_byp1 ? r_byp_wdata : rf_rd1);
    assign rsp_rd2 = !w_rsp_live ? '0 : (r_byp2 ? r_byp_wdata : rf_rd2);
`else
    assign rsp_rd1 = w_rsp_live ? rf_rd1 : '0;
    assign rsp_rd2 = w_rsp_live ? rf_rd2 : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_port_arbiter
// Description : Directed self-checking bench for rf_port_arbiter with a
//               synchronous register-file model preloaded with x_i = 10*i.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_port_arbiter;

    localparam int c_W  = 32;
    localparam int c_AW = 5;

    logic            Clk = 1'b0;
    logic            Rst;
    logic [1:0]      req_valid, req_ready, req_lock, req_we, rsp_valid;
    logic [c_AW-1:0] req_rs1_0, req_rs1_1, req_rs2_0, req_rs2_1, req_rd_0, req_rd_1;
    logic [c_W-1:0]  req_wdata_0, req_wdata_1;
    logic [c_W-1:0]  rsp_rd1, rsp_rd2;
    logic [c_AW-1:0] rf_addr1, rf_addr2, rf_addr3;
    logic            rf_regwrite;
    logic [c_W-1:0]  rf_wdata;
    logic [c_W-1:0]  rf_rd1 = '0;
    logic [c_W-1:0]  rf_rd2 = '0;
    logic [c_W-1:0]  r_regs [32];

    int n_tests = 0;
    int n_fail  = 0;

    rf_port_arbiter #(.REG_WIDTH(c_W), .REG_DEPTH(32), .MAX_LOCK(4)) u_dut (
        .Clk(Clk), .Rst(Rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_lock(req_lock), .req_we(req_we),
        .req_rs1_0(req_rs1_0), .req_rs1_1(req_rs1_1),
        .req_rs2_0(req_rs2_0), .req_rs2_1(req_rs2_1),
        .req_rd_0(req_rd_0), .req_rd_1(req_rd_1),
        .req_wdata_0(req_wdata_0), .req_wdata_1(req_wdata_1),
        .rsp_valid(rsp_valid), .rsp_rd1(rsp_rd1), .rsp_rd2(rsp_rd2),
        .rf_addr1(rf_addr1), .rf_addr2(rf_addr2), .rf_addr3(rf_addr3),
        .rf_regwrite(rf_regwrite), .rf_wdata(rf_wdata),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2)
    );

    always #5 Clk = ~Clk;

    // Register-file model: synchronous reads see the pre-write contents.
    always @(posedge Clk) begin
        rf_rd1 <= (rf_addr1 == 0) ? '0 : r_regs[rf_addr1];
        rf_rd2 <= (rf_addr2 == 0) ? '0 : r_regs[rf_addr2];
        if (rf_regwrite && rf_addr3 != 0) r_regs[rf_addr3] <= rf_wdata;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        req_valid = 2'b00; req_lock = 2'b00; req_we = 2'b00;
        req_rs1_0 = '0; req_rs1_1 = '0; req_rs2_0 = '0; req_rs2_1 = '0;
        req_rd_0 = '0; req_rd_1 = '0; req_wdata_0 = '0; req_wdata_1 = '0;
    endtask

    task automatic nxt();
        @(posedge Clk);
        #1;
    endtask

    logic [1:0]     lock_seq [5] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
    logic [c_W-1:0] exp_same;

    initial begin
        for (int i = 0; i < 32; i++) r_regs[i] = 32'(10 * i);
`ifdef RF_ARB_BYPASS_EN
        exp_same = 32'hDEAD_BEEF;
`else
        exp_same = 32'd70;
`endif
        clr();
        Rst = 1'b1;
        req_valid = 2'b11; req_we = 2'b11; req_rs1_0 = 5'd3; req_wdata_0 = 32'h55;
        nxt(); nxt();
        @(negedge Clk);
        chk("rst_ready",    req_ready,   2'b00);
        chk("rst_rspv",     rsp_valid,   2'b00);
        chk("rst_rd1",      rsp_rd1,     0);
        chk("rst_regwrite", rf_regwrite, 0);
        chk("rst_addr1",    rf_addr1,    0);
        chk("rst_wdata",    rf_wdata,    0);

        // Single read from requester 0
        nxt(); Rst = 1'b0; clr();
        req_valid = 2'b01; req_rs1_0 = 5'd3; req_rs2_0 = 5'd5;
        @(negedge Clk);
        chk("rd_ready", req_ready, 2'b01);
        chk("rd_addr1", rf_addr1, 3);
        chk("rd_addr2", rf_addr2, 5);
        chk("rd_we",    rf_regwrite, 0);
        nxt(); clr();
        @(negedge Clk);
        chk("rd_rspv",  rsp_valid, 2'b01);
        chk("rd_rsp1",  rsp_rd1, 30);
        chk("rd_rsp2",  rsp_rd2, 50);
        chk("rd_idle",  req_ready, 2'b00);

        // Requester 1 alone, returns prio to requester 0
        nxt(); req_valid = 2'b10; req_rs1_1 = 5'd1;
        @(negedge Clk);
        chk("r1_ready", req_ready, 2'b10);
        nxt(); clr();
        @(negedge Clk);
        chk("r1_rspv", rsp_valid, 2'b10);
        chk("r1_rsp1", rsp_rd1, 10);

        // Both valid, no lock: alternate 0,1,0,1
        nxt(); req_valid = 2'b11; req_rs1_0 = 5'd2; req_rs1_1 = 5'd4;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            chk("alt_ready", req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
            if (i > 0) begin
                chk("alt_rspv", rsp_valid, (i % 2 == 0) ? 2'b10 : 2'b01);
                chk("alt_rsp1", rsp_rd1, (i % 2 == 0) ? 40 : 20);
            end
            nxt();
        end
        clr();
        @(negedge Clk);
        chk("alt_last_rspv", rsp_valid, 2'b10);
        chk("alt_last_rsp1", rsp_rd1, 40);

        // Requester 1 locks: 4 grants, one to requester 0, then 1 resumes
        nxt(); req_valid = 2'b10; req_lock = 2'b10;
        @(negedge Clk);
        chk("lock_first", req_ready, 2'b10);
        nxt(); req_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk("lock_seq", req_ready, lock_seq[i]);
            nxt();
        end
        clr();

        // Same-request write/read hazard on x7
        nxt(); req_valid = 2'b01; req_we = 2'b01; req_rd_0 = 5'd7; req_rs1_0 = 5'd7;
        req_wdata_0 = 32'hDEAD_BEEF;
        @(negedge Clk);
        chk("wr_we",    rf_regwrite, 1);
        chk("wr_addr3", rf_addr3, 7);
        chk("wr_wdata", rf_wdata, 32'hDEAD_BEEF);
        nxt(); req_we = 2'b00;
        @(negedge Clk);
        chk("haz_rsp1", rsp_rd1, exp_same);
        nxt(); clr();
        @(negedge Clk);
        chk("raw_rspv", rsp_valid, 2'b01);
        chk("raw_rsp1", rsp_rd1, 32'hDEAD_BEEF);

        // Write to x0 is passed through but reads stay 0
        nxt(); req_valid = 2'b10; req_we = 2'b10; req_rd_1 = 5'd0; req_rs1_1 = 5'd0;
        req_wdata_1 = 32'h1234;
        @(negedge Clk);
        chk("x0_we",   rf_regwrite, 1);
        chk("x0_data", rf_wdata, 32'h1234);
        nxt(); req_we = 2'b00;
        @(negedge Clk);
        chk("x0_same", rsp_rd1, 0);
        nxt(); clr();
        @(negedge Clk);
        chk("x0_rspv", rsp_valid, 2'b10);
        chk("x0_rsp1", rsp_rd1, 0);

        // Reset in the cycle after a grant
        nxt(); req_valid = 2'b01; req_rs1_0 = 5'd3;
        @(negedge Clk);
        chk("mr_grant", req_ready, 2'b01);
        nxt(); Rst = 1'b1; req_valid = 2'b11;
        @(negedge Clk);
        chk("mr_rspv",  rsp_valid, 2'b00);
        chk("mr_ready", req_ready, 2'b00);
        chk("mr_rsp1",  rsp_rd1, 0);
        chk("mr_addr1", rf_addr1, 0);
        nxt(); Rst = 1'b0; clr();
        @(negedge Clk);
        chk("mr_norsp", rsp_valid, 2'b00);
        nxt(); req_valid = 2'b11;
        @(negedge Clk);
        chk("mr_first", req_ready, 2'b01);
        nxt(); clr();
        @(negedge Clk);
        chk("mr_rsp_after", rsp_valid, 2'b01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
